// File: rtl/i2c_slave_mem.sv
// rtl/i2c_slave_mem.sv - I2C slave with byte-addressed memory, 2-flop synced bus sampling

module i2c_slave_mem #(
    parameter logic [6:0] DEVICE_ID = 7'b0000001,
    parameter int         ADDR_W    = 6
) (
    input  logic              clk8x,
    input  logic              reset,
    input  logic              SCL,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [3:0]        state,
    output logic              busy,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_DEV_ADDR = 4'd1,
        S_DEV_ACK  = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_ACK  = 4'd4,
        S_WR_DATA  = 4'd5,
        S_WR_ACK   = 4'd6,
        S_RD_DATA  = 4'd7,
        S_RD_ACK   = 4'd8,
        S_IGNORE   = 4'd9
    } state_t;

    state_t              state_q;
    logic                scl_s1_q, scl_s2_q, scl_p_q;
    logic                sda_s1_q, sda_s2_q, sda_p_q;
    logic [3:0]          bit_cnt_q;
    logic [7:0]          shift_q;
    logic                rw_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic                sda_oe_q;
    logic                wr_valid_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [7:0]          wr_data_q;
    logic [7:0]          mem_q [2**ADDR_W];

    logic                scl_rise, scl_fall, start_det, stop_det;
    logic                byte_done, shifting, mem_we;
    logic [ADDR_W-1:0]   ptr_inc;
    logic [2:0]          bit_idx;
    logic [7:0]          rd_byte, next_byte;

    // Two-flop synchronizers plus one delayed copy for edge detection; idle bus level is high
    always_ff @(posedge clk8x or negedge reset) begin
        if (!reset) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_p_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_p_q  <= 1'b1;
        end else begin
            scl_s1_q <= SCL;
            scl_s2_q <= scl_s1_q;
            scl_p_q  <= scl_s2_q;
            sda_s1_q <= sda_in;
            sda_s2_q <= sda_s1_q;
            sda_p_q  <= sda_s2_q;
        end
    end

    // Bus events and datapath helpers derived from the synchronized lines
    always_comb begin
        scl_rise  = scl_s2_q & ~scl_p_q;
        scl_fall  = ~scl_s2_q & scl_p_q;
        start_det = ~sda_s2_q & sda_p_q & scl_s2_q;
        stop_det  = sda_s2_q & ~sda_p_q & scl_s2_q;
        byte_done = (bit_cnt_q == 4'd8);
        shifting  = (state_q == S_DEV_ADDR) || (state_q == S_MEM_ADDR) ||
                    (state_q == S_WR_DATA)  || (state_q == S_RD_DATA);
        mem_we    = scl_fall && !start_det && !stop_det &&
                    (state_q == S_WR_DATA) && byte_done;
        ptr_inc   = ptr_q + ADDR_W'(1);
        bit_idx   = 3'd7 - bit_cnt_q[2:0];
        rd_byte   = mem_q[ptr_q];
        next_byte = mem_q[ptr_inc];
    end

    // Protocol FSM: bits shift in on SCL rise, state and SDA drive advance on SCL fall
    always_ff @(posedge clk8x or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_valid_q <= 1'b0;
            if (stop_det) begin
                state_q   <= S_IDLE;
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
            end else if (start_det) begin
                state_q   <= S_DEV_ADDR;
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
            end else if (scl_rise) begin
                if (shifting && !byte_done) begin
                    shift_q   <= {shift_q[6:0], sda_s2_q};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end else if (state_q == S_RD_ACK) begin
                    shift_q   <= {shift_q[6:0], sda_s2_q};
                end
            end else if (scl_fall) begin
                case (state_q)
                    S_DEV_ADDR: if (byte_done) begin
                        bit_cnt_q <= '0;
                        rw_q      <= shift_q[0];
                        if (shift_q[7:1] == DEVICE_ID) begin
                            state_q  <= S_DEV_ACK;
                            sda_oe_q <= 1'b1;
                        end else begin
                            state_q  <= S_IGNORE;
                            sda_oe_q <= 1'b0;
                        end
                    end
                    S_DEV_ACK: begin
                        state_q  <= S_MEM_ADDR;
                        sda_oe_q <= 1'b0;
                    end
                    S_MEM_ADDR: if (byte_done) begin
                        ptr_q     <= shift_q[ADDR_W-1:0];
                        bit_cnt_q <= '0;
                        state_q   <= S_MEM_ACK;
                        sda_oe_q  <= 1'b1;
                    end
                    S_MEM_ACK: begin
                        if (rw_q) begin
                            state_q  <= S_RD_DATA;
                            sda_oe_q <= ~rd_byte[7];
                        end else begin
                            state_q  <= S_WR_DATA;
                            sda_oe_q <= 1'b0;
                        end
                    end
                    S_WR_DATA: if (byte_done) begin
                        wr_valid_q <= 1'b1;
                        wr_addr_q  <= ptr_q;
                        wr_data_q  <= shift_q;
                        ptr_q      <= ptr_inc;
                        bit_cnt_q  <= '0;
                        state_q    <= S_WR_ACK;
                        sda_oe_q   <= 1'b1;
                    end
                    S_WR_ACK: begin
                        state_q  <= S_WR_DATA;
                        sda_oe_q <= 1'b0;
                    end
                    S_RD_DATA: begin
                        if (byte_done) begin
                            bit_cnt_q <= '0;
                            state_q   <= S_RD_ACK;
                            sda_oe_q  <= 1'b0;
                        end else begin
                            sda_oe_q  <= ~rd_byte[bit_idx];
                        end
                    end
                    S_RD_ACK: begin
                        // Low on the ack clock means the master wants another byte
                        if (!shift_q[0]) begin
                            ptr_q    <= ptr_inc;
                            state_q  <= S_RD_DATA;
                            sda_oe_q <= ~next_byte[7];
                        end else begin
                            state_q  <= S_IGNORE;
                            sda_oe_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Memory array is intentionally outside reset so contents survive a reset
    always_ff @(posedge clk8x) begin
        if (mem_we) begin
            mem_q[ptr_q] <= shift_q;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign state    = state_q;
    assign busy     = (state_q != S_IDLE);
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: doc/i2c_slave_mem.md
I2C_SLAVE_MEM -- requirements
Module: i2c_slave_mem

Interface
REQ-001 SHALL provide parameter: DEVICE_ID, 7'b0000001, 7-bit bus address this slave answers to.
REQ-002 SHALL provide parameter: ADDR_W, 6, memory address width; depth = 2**ADDR_W bytes.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports as below.
REQ-004 clk8x  in  1  system clock, nominally 8x SCL rate; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 SCL  in  1  I2C clock from master, asynchronous to clk8x.
REQ-007 sda_in  in  1  sampled level of the shared SDA line.
REQ-008 sda_oe  out  1  1 = pull SDA low; 0 = release (open-drain, never drives high).
REQ-009 state  out  4  current FSM state encoding, for debug.
REQ-010 busy  out  1  high from START detect until STOP or return to IDLE.
REQ-011 wr_valid  out  1  one-cycle pulse when a written byte is committed to memory.
REQ-012 wr_addr  out  ADDR_W  memory address of committed byte, valid with wr_valid.
REQ-013 wr_data  out  8  committed byte, valid with wr_valid.

Function
REQ-014 SCL and sda_in SHALL each pass a 2-flop synchronizer; edges detected on synchronized values (detect latency 3 clk8x cycles).
REQ-015 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while synced SCL high.
REQ-016 Bits SHALL be sampled on detected SCL rise; sda_oe SHALL change only on the cycle after detected SCL fall.
REQ-017 All bytes SHALL be MSB first; 9th clock of each byte is ACK (receiver pulls low).
REQ-018 States: IDLE, DEV_ADDR, DEV_ACK, MEM_ADDR, MEM_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-019 IDLE -> DEV_ADDR on START; 8 bits shifted (7 address + R/W).
REQ-020 DEV_ADDR -> DEV_ACK if address == DEVICE_ID (sda_oe=1 for ack clock), else -> IGNORE with sda_oe=0.
REQ-021 DEV_ACK -> MEM_ADDR; 8 bits received, low ADDR_W bits latched as pointer, upper bits ignored; MEM_ACK always acks.
REQ-022 MEM_ACK -> WR_DATA if R/W=0; -> RD_DATA if R/W=1, first data bit driven after the MEM_ACK SCL fall.
REQ-023 WR_DATA: after 8th bit, memory[pointer] written, wr_valid pulses 1 cycle, WR_ACK acks, pointer increments.
REQ-024 RD_DATA: sda_oe = ~bit of memory[pointer]; after 8 bits, SDA released for RD_ACK; master ack samples low -> pointer increments, next RD_DATA; high (NACK) -> IGNORE.
REQ-025 Pointer increment SHALL wrap 2**ADDR_W-1 -> 0.
REQ-026 STOP in any state SHALL go to IDLE, release SDA within 1 cycle, discard partial byte.
REQ-027 START in any non-IDLE state (repeated start) SHALL go to DEV_ADDR, discard partial byte, release SDA.
REQ-028 IGNORE SHALL keep sda_oe=0 until STOP/START.
REQ-029 Memory contents SHALL only change on REQ-023 writes.

Reset
REQ-030 While reset low: state=IDLE, sda_oe=0, busy=0, wr_valid=0, wr_addr=0, wr_data=0, pointer=0, synchronizers=1 (bus idle high).
REQ-031 Reset mid-transfer SHALL abort immediately; after release slave waits for a new START.
REQ-032 Memory array SHALL NOT be cleared by reset.

Verification
REQ-033 Write: START, 0x02 (dev 1, W), 0x01, 0x5F, STOP -> three acks, wr_valid once with wr_addr=0x01 wr_data=0x5F, busy low after STOP.
REQ-034 Read: after REQ-033, START, 0x03, 0x01, 8 clocks, master NACK, STOP -> SDA bits 0,1,0,1,1,1,1,1; state IGNORE then IDLE.
REQ-035 Wrong address: START, 0x04 -> sda_oe stays 0 for all clocks until STOP; no wr_valid.
REQ-036 Burst wrap: write 0x3F then 0xAA, 0xBB in one transaction -> wr_valid at addr 0x3F (0xAA) then 0x00 (0xBB).
REQ-037 Abort: STOP after 4 bits of write data, then reset low mid-address of new transfer -> no memory change, sda_oe=0, state=IDLE.
REQ-038 Repeated start: write header to 0x05, START, read header 0x03, 0x05 -> read returns memory[0x05], no write committed.
